// File: rtl/verilog_const_concat_pkg.sv
// rtl/verilog_const_concat_pkg.sv - mode encodings and per-bit operator for the const/concat pipe
package verilog_const_concat_pkg;

  localparam int MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_AND = 2'b00;
  localparam logic [MODE_W-1:0] MODE_OR  = 2'b01;
  localparam logic [MODE_W-1:0] MODE_BUF = 2'b10;
  localparam logic [MODE_W-1:0] MODE_INV = 2'b11;

  // Bit-sliced so any channel width can reuse it without width juggling.
  function automatic logic apply_mode(input logic data, input logic [MODE_W-1:0] mode,
                                      input logic and_mask, input logic or_mask);
    logic res;
    case (mode)
      MODE_AND: res = data & and_mask;
      MODE_OR:  res = data | or_mask;
      MODE_BUF: res = data;
      default:  res = ~data;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/verilog_const_concat_stage.sv
// rtl/verilog_const_concat_stage.sv - one valid/data register slice with load/advance handshake
module verilog_const_concat_stage #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         up_valid_i,
  input  logic [W-1:0] up_data_i,
  output logic         up_ready_o,
  input  logic         down_ready_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  logic         open;

  // Data only reloads on a real beat, so the slice keeps its last value across bubbles.
  always_comb begin
    open    = !valid_q || down_ready_i;
    valid_d = open ? up_valid_i : valid_q;
    data_d  = (open && up_valid_i) ? up_data_i : data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign up_ready_o = open;
  assign valid_o    = valid_q;
  assign data_o     = data_q;

endmodule

// File: rtl/verilog_const_concat_pipe.sv
// rtl/verilog_const_concat_pipe.sv - per-channel const-mask op into a DEPTH-stage valid/ready pipe (option: VERILOG_CONST_CONCAT_PIPE_PARITY_EN)
module verilog_const_concat_pipe
  import verilog_const_concat_pkg::*;
#(
  parameter int               NCH      = 4,
  parameter int               WIDTH    = 4,
  parameter int               DEPTH    = 2,
  parameter logic [WIDTH-1:0] AND_MASK = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] OR_MASK  = {WIDTH{1'b0}}
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NCH*WIDTH-1:0]  in_data,
  input  logic [2*NCH-1:0]      mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NCH*WIDTH-1:0]  out_data,
  output logic [WIDTH-1:0]      out_hi,
  output logic [WIDTH-1:0]      out_lo,
`ifdef VERILOG_CONST_CONCAT_PIPE_PARITY_EN
  output logic                  out_par,
`endif
  output logic [15:0]           beat_cnt
);

  localparam int DW = NCH * WIDTH;
`ifdef VERILOG_CONST_CONCAT_PIPE_PARITY_EN
  localparam int SW = DW + 1;
`else
  localparam int SW = DW;
`endif

  logic [DW-1:0]  op_data;
  logic [DEPTH:0] stg_valid;
  logic [DEPTH:0] stg_ready;
  logic [SW-1:0]  stg_data [0:DEPTH];
  logic [15:0]    beat_cnt_q, beat_cnt_d;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
      assign op_data[c*WIDTH+b] = apply_mode(in_data[c*WIDTH+b], mode[MODE_W*c +: MODE_W],
                                             AND_MASK[b], OR_MASK[b]);
    end
  end

  assign stg_valid[0] = in_valid;
`ifdef VERILOG_CONST_CONCAT_PIPE_PARITY_EN
  assign stg_data[0]  = {^op_data, op_data};
`else
  assign stg_data[0]  = op_data;
`endif
  assign stg_ready[DEPTH] = out_ready;
  assign in_ready         = stg_ready[0];

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    verilog_const_concat_stage #(.W(SW)) u_stage (
      .clk          (clk),
      .rst          (rst),
      .up_valid_i   (stg_valid[k]),
      .up_data_i    (stg_data[k]),
      .up_ready_o   (stg_ready[k]),
      .down_ready_i (stg_ready[k+1]),
      .valid_o      (stg_valid[k+1]),
      .data_o       (stg_data[k+1])
    );
  end

  assign out_valid = stg_valid[DEPTH];
  assign out_data  = stg_data[DEPTH][DW-1:0];
  assign out_hi    = out_data[(NCH-1)*WIDTH +: WIDTH];
  assign out_lo    = out_data[0 +: WIDTH];
`ifdef VERILOG_CONST_CONCAT_PIPE_PARITY_EN
  assign out_par   = stg_data[DEPTH][DW];
`endif

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (out_valid && out_ready) beat_cnt_d = beat_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) beat_cnt_q <= '0;
    else     beat_cnt_q <= beat_cnt_d;
  end

  assign beat_cnt = beat_cnt_q;

endmodule

// File: doc/verilog_const_concat_pipe.md
Name: verilog_const_concat_pipe

Overview:
- Parametrised, multi-channel, pipelined successor to the flat gate-level constant/concat test netlist.
- Each channel applies a per-channel mode:
  - AND with a constant mask
  - OR with a constant mask
  - buffer
  - invert
- Results pass through a DEPTH-stage valid/ready pipeline.
- Outputs are a full concatenated bus plus high/low part-select views.
- Used as the reader/timing regression block for bus constants, concatenation, part/bit selects and sequential arcs.

Parameters:
- NCH, 4, number of channels (1..8)
- WIDTH, 4, bits per channel (1..16)
- DEPTH, 2, pipeline stages (1..4)
- AND_MASK, {WIDTH{1'b1}}, constant operand for mode AND
- OR_MASK, {WIDTH{1'b0}}, constant operand for mode OR

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  input beat valid
- in_ready  output  1  pipeline can accept a beat
- in_data  input  NCH*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH]
- mode  input  2*NCH  channel c mode at [2c +: 2]; 00=AND, 01=OR, 10=BUF, 11=INV
- out_valid  output  1  output beat valid
- out_ready  input  1  downstream accepts
- out_data  output  NCH*WIDTH  concatenated channel results, same packing as in_data
- out_hi  output  WIDTH  part select of the highest channel
- out_lo  output  WIDTH  part select of channel 0
- beat_cnt  output  16  count of beats delivered (out_valid && out_ready)

Behaviour:
- Reset (async assert, sync-released by the environment):
  - All stage valid bits clear; all data regs, out_data, out_hi, out_lo and beat_cnt read 0.
  - in_ready reads 1 during reset.
- Combinational op at stage 0 input, per channel: AND: d & AND_MASK; OR: d | OR_MASK; BUF: d; INV: ~d.
- mode is sampled with in_data on the same accepted beat; it is never applied retroactively.
- Pipeline:
  - DEPTH register stages, each holding {valid, NCH*WIDTH data}.
  - Stage k loads from stage k-1 when (stage k empty) or (stage k advancing); stage DEPTH-1 advances when out_ready.
  - in_ready = stage 0 empty or stage 0 advancing; bubbles collapse.
- Latency: exactly DEPTH cycles from acceptance to out_valid when never stalled. Throughput is 1 beat/cycle.
- Stall: out_valid high and out_ready low holds out_data stable until taken. Once the pipe is full, in_ready drops in the same cycle.
- Full pipe with simultaneous out_ready and in_valid: one beat in and one out in the same cycle; no loss, no duplication.
- Empty pipe with out_ready: no effect. out_data holds its last value (not cleared) while out_valid is low.
- beat_cnt increments on each delivered beat and wraps 16'hFFFF -> 0.
- Reset mid-operation: all in-flight beats are discarded and nothing is delivered afterwards.
- out_hi = out_data[(NCH-1)*WIDTH +: WIDTH]; out_lo = out_data[0 +: WIDTH]. When NCH=1 both equal out_data.

Optional Feature:
- Macro: VERILOG_CONST_CONCAT_PIPE_PARITY_EN.
- Defined:
  - Adds output out_par (1 bit) = XOR-reduce of out_data.
  - Registered alongside the data, reset to 0, same valid qualification.
- Undefined:
  - Port absent; no parity logic.

Decomposition:
- Package verilog_const_concat_pkg:
  - mode encoding constants MODE_AND=2'b00, MODE_OR=2'b01, MODE_BUF=2'b10, MODE_INV=2'b11
  - MODE_W=2
  - function apply_mode(data, mode, and_mask, or_mask)
- Sub-module verilog_const_concat_stage: one valid/data register slice with load/advance handshake, instantiated DEPTH times via generate.

Test Plan:
- Reset: assert rst mid-stream with 2 beats in flight -> out_valid=0, out_data=0, beat_cnt=0 immediately; no beats appear after release.
- Modes, NCH=4/WIDTH=4/DEPTH=2, AND_MASK=4'b1010, OR_MASK=4'b0001, in_data=16'h5A3C, mode=8'b11_10_01_00:
  - accepted at cycle t -> out_valid at t+2
  - out_data=16'hA_A_3_8 (INV 5 -> A, BUF A, OR 3 -> 3, AND C -> 8)
  - out_hi=4'hA, out_lo=4'h8
- Backpressure: out_ready=0 for 5 cycles while in_valid=1 -> in_ready falls after 2 accepted beats; out_data stable. Releasing out_ready delivers the beats in order, with beat_cnt +1 per cycle.
- Streaming: 100 back-to-back beats, out_ready=1 -> 100 outputs, contiguous, in order, beat_cnt=100.
- Wrap: preload via 65537 deliveries -> beat_cnt=1.
- Parity (macro defined): out_data=16'h0007 -> out_par=1; 16'h0003 -> out_par=0.
